conv_engine_fsm: RTL

Parametrised convolution engine: it sequences a K×K convolution over a stream of N×N datasets held in a single-port input memory. It owns the weight store, the address generation and a single signed MAC, and delivers each output pixel over a valid/ready port to the downstream FC stage. It is the successor to the fixed 3×3, four-accumulator controller. Unlike that controller, it generalises kernel size and widths, stalls under backpressure, and skips datasets smaller than the kernel.

---
 rtl/conv_engine_fsm.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_engine_fsm.sv
// conv_engine_fsm
//   Sequences a KxK signed convolution over a chain of NxN datasets held in a
//   single-port memory (one-cycle read latency). It loads the weights, walks
//   every valid output position, accumulates with one MAC and hands each
//   result downstream over a valid/ready port.
// Ports:
//   clk, reset_b          clock, asynchronous active-low reset
//   dut_run               start request (rising edge seen in IDLE)
//   dut_busy              high whenever not IDLE
//   mem_rd/mem_addr       read strobe and address; mem_rdata one cycle later
//   res_data/res_valid/res_ready/res_last   result stream
//   matrix_done_flag      pulse per finished or skipped dataset
//   done                  pulse after the terminator word has been read
module conv_engine_fsm #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int ADDR_W = 12,
   parameter int K      = 3
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              dut_run,
   output logic              dut_busy,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_last,
   output logic              matrix_done_flag,
   output logic              done
);

   localparam int KK = K * K;
   localparam int TW = $clog2(KK + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_READ_N = 3'd2;
   localparam logic [2:0] S_WAIT_N = 3'd3;
   localparam logic [2:0] S_CALC   = 3'd4;
   localparam logic [2:0] S_DRAIN  = 3'd5;
   localparam logic [2:0] S_SEND   = 3'd6;
   localparam logic [2:0] S_NEXT   = 3'd7;

   logic [2:0]               state;
   logic                     run_q;
   logic [ADDR_W-1:0]        base;
   logic [TW-1:0]            tidx;      // weight-load index, then linear tap index
   logic [TW-1:0]            ti, tj;    // tap row / column
   logic                     cap_v;
   logic [TW-1:0]            cap_idx;
   logic                     mac_v, mac_first;
   logic [TW-1:0]            mac_idx;
   logic signed [DATA_W-1:0] weight [KK];
   logic [DATA_W-1:0]        nval, r, c;
   logic signed [ACC_W-1:0]  acc;
   logic                     done_q;

   logic [ADDR_W-1:0]        row, col, calc_addr, nxt_base;
   logic [DATA_W-1:0]        lim;
   logic                     at_last;
   logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;

   always_comb begin
      row       = ADDR_W'(r) + ADDR_W'(ti);
      col       = ADDR_W'(c) + ADDR_W'(tj);
      calc_addr = base + ADDR_W'(1) + row * ADDR_W'(nval) + col;
      nxt_base  = base + ADDR_W'(1) + ADDR_W'(nval) * ADDR_W'(nval);
      lim       = nval - DATA_W'(K);
      at_last   = (r == lim) && (c == lim);
      a_ext     = (2*DATA_W)'($signed(mem_rdata));
      b_ext     = (2*DATA_W)'(weight[mac_idx]);
      prod      = a_ext * b_ext;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state     <= S_IDLE;
         // Starts high so a dut_run already asserted at reset release is not an edge.
         run_q     <= 1'b1;
         base      <= '0;
         tidx      <= '0;
         ti        <= '0;
         tj        <= '0;
         cap_v     <= 1'b0;
         cap_idx   <= '0;
         mac_v     <= 1'b0;
         mac_first <= 1'b0;
         mac_idx   <= '0;
         nval      <= '0;
         r         <= '0;
         c         <= '0;
         acc       <= '0;
         done_q    <= 1'b0;
         for (int unsigned k = 0; k < KK; k++) weight[k] <= '0;
      end else begin
         run_q  <= dut_run;
         cap_v  <= 1'b0;
         mac_v  <= 1'b0;
         done_q <= 1'b0;
         // Read data lands one cycle after issue, so capture and MAC trail the address.
         if (cap_v) weight[cap_idx] <= mem_rdata;
         if (mac_v) acc <= (mac_first ? '0 : acc) + ACC_W'(prod);
         case (state)
            S_IDLE: begin
               if (dut_run && !run_q) begin
                  state <= S_LOAD_W;
                  tidx  <= '0;
                  base  <= ADDR_W'(KK);
               end
            end
            S_LOAD_W: begin
               cap_v   <= 1'b1;
               cap_idx <= tidx;
               if (tidx == TW'(KK - 1)) begin
                  tidx  <= '0;
                  state <= S_READ_N;
               end else begin
                  tidx <= tidx + TW'(1);
               end
            end
            S_READ_N: state <= S_WAIT_N;
            S_WAIT_N: begin
               if (mem_rdata == '1) begin
                  done_q <= 1'b1;
                  state  <= S_IDLE;
               end else begin
                  // N is kept even for skipped datasets: NEXT needs it to step base.
                  nval <= mem_rdata;
                  if (mem_rdata < DATA_W'(K)) begin
                     state <= S_NEXT;
                  end else begin
                     r     <= '0;
                     c     <= '0;
                     ti    <= '0;
                     tj    <= '0;
                     tidx  <= '0;
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               mac_v     <= 1'b1;
               mac_first <= (tidx == '0);
               mac_idx   <= tidx;
               tidx      <= tidx + TW'(1);
               if (tj == TW'(K - 1)) begin
                  tj <= '0;
                  if (ti == TW'(K - 1)) begin
                     ti    <= '0;
                     tidx  <= '0;
                     state <= S_DRAIN;
                  end else begin
                     ti <= ti + TW'(1);
                  end
               end else begin
                  tj <= tj + TW'(1);
               end
            end
            S_DRAIN: state <= S_SEND;
            S_SEND: begin
               if (res_ready) begin
                  if (at_last) begin
                     state <= S_NEXT;
                  end else begin
                     if (c == lim) begin
                        c <= '0;
                        r <= r + DATA_W'(1);
                     end else begin
                        c <= c + DATA_W'(1);
                     end
                     state <= S_CALC;
                  end
               end
            end
            S_NEXT: begin
               base  <= nxt_base;
               state <= S_READ_N;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      dut_busy         = (state != S_IDLE);
      mem_rd           = (state == S_LOAD_W) || (state == S_READ_N) || (state == S_CALC);
      case (state)
         S_LOAD_W: mem_addr = ADDR_W'(tidx);
         S_READ_N: mem_addr = base;
         S_CALC:   mem_addr = calc_addr;
         default:  mem_addr = '0;
      endcase
      res_valid        = (state == S_SEND);
      res_data         = res_valid ? acc : '0;
      res_last         = res_valid && at_last;
      matrix_done_flag = (state == S_NEXT);
      done             = done_q;
   end

endmodule
